// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB initiator port.
package apb_master_pkg;

  localparam int unsigned APB_DATA_W = 32;

  // Returned on rdata_o when the access was aborted (timeout or misalignment).
  localparam logic [APB_DATA_W-1:0] APB_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_e;

  // Response payload handed back to the requester.
  typedef struct packed {
    logic                  err;
    logic [APB_DATA_W-1:0] rdata;
  } apb_rsp_t;

  // Bits needed to count up to and including the timeout limit.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    if (cycles == 0) begin
      return 1;
    end
    return unsigned'($clog2(cycles + 32'd1));
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; flags the cycle on which the limit is reached.
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic HRESETn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    // Timeout disabled: the counter is not built and never expires.
    assign o_expired_c = 1'b0;
  end else begin : g_on
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, hold at the limit, clear when told to.
    always_ff @(posedge clk_i or negedge HRESETn) begin
      if (!HRESETn) begin
        r_cnt <= '0;
      end else if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    // Expiry is seen on the waiting cycle whose increment reaches the limit.
    assign o_expired_c = i_en & (r_cnt >= CNT_LAST);
  end

endmodule

// File: rtl/apb_master_port.sv
// Single-outstanding req/gnt/rvalid to APB3 initiator with PREADY timeout.
module apb_master_port
  import apb_master_pkg::*;
#(
  parameter int unsigned         APB_ADDR_WIDTH = 12,
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter logic [APB_DATA_W-1:0] ERR_RDATA    = APB_ERR_RDATA_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_W-1:0]     wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_W-1:0]     rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_W-1:0]     PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_W-1:0]     PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_mst_state_e            r_state,   w_state_nxt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr,   w_paddr_nxt;
  logic [APB_DATA_W-1:0]     r_pwdata,  w_pwdata_nxt;
  logic                      r_pwrite,  w_pwrite_nxt;
  logic                      r_psel,    w_psel_nxt;
  logic                      r_penable, w_penable_nxt;
  logic                      r_rvalid,  w_rvalid_nxt;
  apb_rsp_t                  r_rsp,     w_rsp_nxt;

  logic w_gnt;
  logic w_accept;
  logic w_aligned;
  logic w_wait;
  logic w_expired;

  // Grant only while idle; held low during reset so every output reads 0.
  assign w_gnt     = req_i & HRESETn & (r_state == ST_IDLE);
  assign w_accept  = req_i & w_gnt;
  assign w_aligned = (addr_i[1:0] == 2'b00);
  assign w_wait    = (r_state == ST_ACCESS) & ~PREADY;

  // Wait-state counter, cleared whenever the FSM is outside ACCESS.
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i       (clk_i),
    .HRESETn     (HRESETn),
    .i_clr       (r_state != ST_ACCESS),
    .i_en        (w_wait),
    .o_expired_c (w_expired)
  );

  // Next-state and next-output decode; PREADY has priority over expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_paddr_nxt  = r_paddr;
    w_pwdata_nxt = r_pwdata;
    w_pwrite_nxt = r_pwrite;
    w_rsp_nxt    = r_rsp;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_aligned) begin
            w_paddr_nxt  = addr_i;
            w_pwdata_nxt = wdata_i;
            w_pwrite_nxt = we_i;
            w_state_nxt  = ST_SETUP;
          end else begin
            w_rsp_nxt.err   = 1'b1;
            w_rsp_nxt.rdata = ERR_RDATA;
            w_state_nxt     = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_rsp_nxt.err   = PSLVERR;
          w_rsp_nxt.rdata = r_pwrite ? '0 : PRDATA;
          w_state_nxt     = ST_RESP;
        end else if (w_expired) begin
          w_rsp_nxt.err   = 1'b1;
          w_rsp_nxt.rdata = ERR_RDATA;
          w_state_nxt     = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_psel_nxt    = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
    w_penable_nxt = (w_state_nxt == ST_ACCESS);
    w_rvalid_nxt  = (w_state_nxt == ST_RESP);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rsp     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rsp     <= w_rsp_nxt;
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rsp.rdata;
  assign err_o    = r_rsp.err;
  assign PADDR    = r_paddr;
  assign PWDATA   = r_pwdata;
  assign PWRITE   = r_pwrite;
  assign PSEL     = r_psel;
  assign PENABLE  = r_penable;

endmodule

// File: tb/tb_apb_master_port.sv
// Directed bench for apb_master_port with a response scoreboard.
module tb_apb_master_port;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 4;

  logic          clk_i = 1'b0;
  logic          HRESETn;
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_master_port #(
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk_i    (clk_i),
    .HRESETn  (HRESETn),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_m;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   resp_cnt = 0;
  int   rsp_cyc  = 0;
  int   g_cyc    = 0;
  int   na;
  int   np;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic e, input logic [31:0] r);
    exp_t x;
    x.err   = e;
    x.rdata = r;
    exp_q.push_back(x);
  endtask

  // Scoreboard: every response pops and checks the oldest expectation.
  always @(negedge clk_i) begin
    if (HRESETn && rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(rvalid_o), 32'd0);
      end else begin
        exp_m = exp_q.pop_front();
        chk("rsp_err", 32'(err_o), 32'(exp_m.err));
        chk("rsp_rdata", rdata_o, exp_m.rdata);
      end
      resp_cnt++;
      rsp_cyc = cyc;
    end
  end

  // Present one request, check the grant, record the expected response.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd, input string tag);
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    @(negedge clk_i); #1;
    chk({tag, "_gnt"}, 32'(gnt_o), 32'd1);
    g_cyc = cyc;
    push_exp(e_err, e_rd);
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  // Wait (bounded) for the next response and check its latency from the grant.
  task automatic wait_rsp(input string tag, input int lat, output int n_acc, output int n_psel);
    int start;
    start  = resp_cnt;
    n_acc  = 0;
    n_psel = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i); #1;
      if (resp_cnt != start) break;
      if (PSEL) n_psel++;
      if (PSEL && PENABLE) n_acc++;
    end
    if (resp_cnt == start) begin
      chk({tag, "_resp_timeout"}, 32'(resp_cnt), 32'(start + 1));
    end else begin
      chk({tag, "_latency"}, 32'(rsp_cyc - g_cyc), 32'(lat));
      chk({tag, "_psel_in_resp"}, 32'(PSEL), 32'd0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rst_psel",    32'(PSEL),     32'd0);
    chk("rst_penable", 32'(PENABLE),  32'd0);
    chk("rst_rvalid",  32'(rvalid_o), 32'd0);
    chk("rst_paddr",   32'(PADDR),    32'd0);
    chk("rst_pwdata",  PWDATA,        32'd0);
    chk("rst_pwrite",  32'(PWRITE),   32'd0);
    chk("rst_err",     32'(err_o),    32'd0);
    chk("rst_rdata",   rdata_o,       32'd0);
    req_i = 1'b1; #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    req_i = 1'b0;
    @(posedge clk_i); #1;
    HRESETn = 1'b1;

    // Zero-wait write
    PREADY = 1'b1;
    issue(1'b1, 12'h004, 32'hA5A5_0001, 1'b0, 32'h0, "wr0");
    @(negedge clk_i); #1;
    chk("wr0_setup_psel",    32'(PSEL),    32'd1);
    chk("wr0_setup_penable", 32'(PENABLE), 32'd0);
    chk("wr0_setup_paddr",   32'(PADDR),   32'h004);
    chk("wr0_setup_pwdata",  PWDATA,       32'hA5A5_0001);
    chk("wr0_setup_pwrite",  32'(PWRITE),  32'd1);
    chk("wr0_gnt_busy",      32'(gnt_o),   32'd0);
    @(negedge clk_i); #1;
    chk("wr0_access_psel",    32'(PSEL),    32'd1);
    chk("wr0_access_penable", 32'(PENABLE), 32'd1);
    chk("wr0_access_paddr",   32'(PADDR),   32'h004);
    chk("wr0_access_pwdata",  PWDATA,       32'hA5A5_0001);
    wait_rsp("wr0", 3, na, np);
    @(negedge clk_i); #1;
    chk("idle_hold_paddr",  32'(PADDR), 32'h004);
    chk("idle_hold_pwdata", PWDATA,     32'hA5A5_0001);
    chk("idle_psel",        32'(PSEL),  32'd0);

    // Read with three wait states
    PREADY = 1'b0;
    issue(1'b0, 12'h010, 32'h0, 1'b0, 32'h1234_5678, "rd3w");
    repeat (3) begin @(posedge clk_i); #1; end
    @(negedge clk_i); #1;
    chk("rd3w_waiting_penable", 32'(PENABLE),  32'd1);
    chk("rd3w_waiting_rvalid",  32'(rvalid_o), 32'd0);
    @(posedge clk_i); #1;
    PREADY = 1'b1; PRDATA = 32'h1234_5678;
    wait_rsp("rd3w", 6, na, np);
    PREADY = 1'b0; PRDATA = '0;

    // Slave error; PSLVERR without PREADY is ignored first
    PSLVERR = 1'b1; PRDATA = 32'h0BAD_F00D;
    issue(1'b0, 12'h100, 32'h0, 1'b1, 32'h0BAD_F00D, "slverr");
    @(posedge clk_i); #1;
    @(negedge clk_i); #1;
    chk("slverr_access_penable", 32'(PENABLE), 32'd1);
    @(posedge clk_i); #1;
    PREADY = 1'b1;
    @(negedge clk_i); #1;
    chk("slverr_noready_psel",   32'(PSEL),     32'd1);
    chk("slverr_noready_rvalid", 32'(rvalid_o), 32'd0);
    wait_rsp("slverr", 4, na, np);
    PREADY = 1'b0; PSLVERR = 1'b0;

    // Timeout with PREADY stuck low
    PRDATA = 32'h5555_AAAA;
    issue(1'b0, 12'h020, 32'h0, 1'b1, 32'hDEAD_BEEF, "tmo");
    wait_rsp("tmo", 6, na, np);
    chk("tmo_access_cycles", 32'(na), 32'd4);

    // PREADY on the last allowed cycle completes normally
    issue(1'b0, 12'h024, 32'h0, 1'b0, 32'hCAFE_0004, "tmo_race");
    repeat (4) begin @(posedge clk_i); #1; end
    PREADY = 1'b1; PRDATA = 32'hCAFE_0004;
    wait_rsp("tmo_race", 6, na, np);
    PREADY = 1'b0;

    // Misaligned access never selects the slave
    issue(1'b0, 12'h006, 32'h0, 1'b1, 32'hDEAD_BEEF, "misal");
    wait_rsp("misal", 1, na, np);
    chk("misal_psel_count", 32'(np),    32'd0);
    chk("misal_paddr_hold", 32'(PADDR), 32'h024);

    // Back-to-back writes with req held high
    PREADY = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 12'h008; wdata_i = 32'h1111_0008;
    @(negedge clk_i); #1;
    chk("b2b_gnt0", 32'(gnt_o), 32'd1);
    g_cyc = cyc;
    push_exp(1'b0, 32'h0);
    @(posedge clk_i); #1;
    addr_i = 12'h00C; wdata_i = 32'h2222_000C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      chk("b2b_gnt_low", 32'(gnt_o), 32'd0);
    end
    @(negedge clk_i); #1;
    chk("b2b_gnt1",    32'(gnt_o),       32'd1);
    chk("b2b_spacing", 32'(cyc - g_cyc), 32'd4);
    g_cyc = cyc;
    push_exp(1'b0, 32'h0);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i); #1;
    chk("b2b_paddr",  32'(PADDR), 32'h00C);
    chk("b2b_pwdata", PWDATA,     32'h2222_000C);
    wait_rsp("b2b", 3, na, np);

    // Reset in the middle of a waiting read
    PREADY = 1'b0;
    issue(1'b0, 12'h040, 32'h0, 1'b0, 32'h0, "rst_abort");
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h044;
    @(negedge clk_i); #1;
    chk("rst_pre_penable", 32'(PENABLE), 32'd1);
    @(posedge clk_i); #1;
    HRESETn = 1'b0;
    exp_q.delete();
    #1;
    chk("rstmid_psel",    32'(PSEL),     32'd0);
    chk("rstmid_penable", 32'(PENABLE),  32'd0);
    chk("rstmid_rvalid",  32'(rvalid_o), 32'd0);
    chk("rstmid_paddr",   32'(PADDR),    32'd0);
    chk("rstmid_gnt",     32'(gnt_o),    32'd0);
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rstmid_rvalid_hold", 32'(rvalid_o), 32'd0);
    @(posedge clk_i); #1;
    HRESETn = 1'b1;
    PREADY = 1'b1; PRDATA = 32'h7777_0044;
    @(negedge clk_i); #1;
    chk("rstrel_gnt", 32'(gnt_o), 32'd1);
    g_cyc = cyc;
    push_exp(1'b0, 32'h7777_0044);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_rsp("post_rst", 3, na, np);

    repeat (4) @(negedge clk_i);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
